// File: rtl/multicycle_sequencer_pkg.sv
// Shared encodings for the multi-cycle RISC-V control path:
// opcodes, sequencer states and write-back / next-PC selects.
package multicycle_sequencer_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_TRAP    = 3'd5
    } state_t;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_JALR  = 2'd2;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_sequencer_wait_watchdog.sv
// Counts consecutive memory wait cycles; flags the LIMIT-th one
// so the sequencer can abort a stalled handshake.
module seq_wait_watchdog #(
    parameter int LIMIT = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic wait_i,
    output logic expired_o
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (wait_i && (cnt_q != W'(LIMIT))) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds the waits already seen, so this is the LIMIT-th one
    assign expired_o = wait_i && (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/multicycle_sequencer.sv
// FETCH/DECODE/EXECUTE/MEM/WB control FSM with retire counter and trap.
// Define MEM_TIMEOUT_EN to add the memory-wait watchdog and bus_err.
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_write,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             pc_write,
    output logic [1:0]       pc_sel,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             bus_err,
    output logic             instr_retired,
    output logic [CNT_W-1:0] retire_count
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;
    logic             timeout;

`ifdef MEM_TIMEOUT_EN
    logic wait_cyc;

    assign wait_cyc = ((state_q == S_FETCH) && !imem_ready)
                   || ((state_q == S_MEM) && !dmem_ready);

    seq_wait_watchdog #(
        .LIMIT     (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (state_d != state_q),
        .wait_i    (wait_cyc),
        .expired_o (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        illegal_d     = illegal_q;
        bus_err_d     = bus_err_q;
        imem_req      = 1'b0;
        ir_write      = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        reg_write     = 1'b0;
        wb_sel        = WB_ALU;
        pc_write      = 1'b0;
        pc_sel        = PC_PLUS4;
        instr_retired = 1'b0;
        // Reset masks every output; state_d is ignored by the register
        if (!reset) begin
            unique case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_write = 1'b1;
                        state_d  = S_DECODE;
                    end else if (timeout) begin
                        state_d   = S_TRAP;
                        bus_err_d = 1'b1;
                    end
                end
                S_DECODE: begin
                    if (is_legal(opcode)) begin
                        state_d = S_EXECUTE;
                    end else begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end
                end
                S_EXECUTE: begin
                    case (opcode)
                        OP_LOAD, OP_STORE: state_d = S_MEM;
                        OP_BRANCH: begin
                            pc_write      = 1'b1;
                            pc_sel        = branch_taken ? PC_IMM : PC_PLUS4;
                            instr_retired = 1'b1;
                            state_d       = S_FETCH;
                        end
                        OP_R, OP_IMM, OP_LUI, OP_AUIPC,
                        OP_JAL, OP_JALR: state_d = S_WB;
                        default: begin
                            state_d   = S_TRAP;
                            illegal_d = 1'b1;
                        end
                    endcase
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (opcode == OP_STORE);
                    if (dmem_ready) begin
                        if (opcode == OP_STORE) begin
                            pc_write      = 1'b1;
                            instr_retired = 1'b1;
                            state_d       = S_FETCH;
                        end else begin
                            state_d = S_WB;
                        end
                    end else if (timeout) begin
                        state_d   = S_TRAP;
                        bus_err_d = 1'b1;
                    end
                end
                S_WB: begin
                    reg_write     = 1'b1;
                    pc_write      = 1'b1;
                    instr_retired = 1'b1;
                    state_d       = S_FETCH;
                    case (opcode)
                        OP_LOAD: wb_sel = WB_MEM;
                        OP_JAL: begin
                            wb_sel = WB_PC4;
                            pc_sel = PC_IMM;
                        end
                        OP_JALR: begin
                            wb_sel = WB_PC4;
                            pc_sel = PC_JALR;
                        end
                        default: wb_sel = WB_ALU;
                    endcase
                end
                S_TRAP: state_d = S_TRAP;
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            if (instr_retired) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign state        = reset ? 3'd0 : state_q;
    assign illegal      = illegal_q & ~reset;
    assign bus_err      = bus_err_q & ~reset;
    assign retire_count = reset ? '0 : cnt_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer (timeout checks active
// only when built with MEM_TIMEOUT_EN, using TIMEOUT_CYCLES=4).
module tb_multicycle_sequencer;

    logic        clk;
    logic        reset;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic        imem_ready;
    logic        dmem_ready;
    logic        imem_req;
    logic        ir_write;
    logic        dmem_req;
    logic        dmem_we;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic        pc_write;
    logic [1:0]  pc_sel;
    logic [2:0]  state;
    logic        illegal;
    logic        bus_err;
    logic        instr_retired;
    logic [31:0] retire_count;

    int errors = 0;
    int checks = 0;

    multicycle_sequencer #(
        .CNT_W          (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .branch_taken  (branch_taken),
        .imem_ready    (imem_ready),
        .dmem_ready    (dmem_ready),
        .imem_req      (imem_req),
        .ir_write      (ir_write),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .reg_write     (reg_write),
        .wb_sel        (wb_sel),
        .pc_write      (pc_write),
        .pc_sel        (pc_sel),
        .state         (state),
        .illegal       (illegal),
        .bus_err       (bus_err),
        .instr_retired (instr_retired),
        .retire_count  (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packed strobe vector: imem_req,ir_write,dmem_req,dmem_we,
    // reg_write,pc_write,instr_retired
    function automatic logic [31:0] strobes();
        return {25'd0, imem_req, ir_write, dmem_req, dmem_we,
                reg_write, pc_write, instr_retired};
    endfunction

    initial begin
        reset        = 1'b1;
        opcode       = 7'h00;
        branch_taken = 1'b0;
        imem_ready   = 1'b0;
        dmem_ready   = 1'b0;
        tick();
        tick();
        chk("rst_strobes", strobes(), 32'h0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_count", retire_count, 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_buserr", 32'(bus_err), 32'd0);

        // ADD: cycle 1 FETCH .. cycle 4 WB
        reset      = 1'b0;
        opcode     = 7'b0110011;
        imem_ready = 1'b1;
        #1;
        chk("add_c1_strobes", strobes(), 32'b1100000);
        chk("add_c1_state", 32'(state), 32'd0);
        tick();
        chk("add_c2_state", 32'(state), 32'd1);
        chk("add_c2_strobes", strobes(), 32'h0);
        tick();
        chk("add_c3_state", 32'(state), 32'd2);
        chk("add_c3_strobes", strobes(), 32'h0);
        tick();
        chk("add_c4_state", 32'(state), 32'd4);
        chk("add_c4_strobes", strobes(), 32'b0000111);
        chk("add_c4_wbsel", 32'(wb_sel), 32'd0);
        chk("add_c4_pcsel", 32'(pc_sel), 32'd0);
        chk("add_c4_count", retire_count, 32'd0);
        tick();
        chk("add_c5_count", retire_count, 32'd1);

        // LW with 3 wait cycles; FETCH of LW is this cycle
        opcode = 7'b0000011;
        chk("lw_fetch_irw", 32'(ir_write), 32'd1);
        tick();
        tick();
        chk("lw_exec_state", 32'(state), 32'd2);
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) dmem_ready = 1'b1;
            #1;
            chk("lw_mem_state", 32'(state), 32'd3);
            chk("lw_mem_req", 32'(dmem_req), 32'd1);
            chk("lw_mem_we", 32'(dmem_we), 32'd0);
            chk("lw_mem_regw", 32'(reg_write), 32'd0);
            tick();
        end
        dmem_ready = 1'b0;
        chk("lw_wb_state", 32'(state), 32'd4);
        chk("lw_wb_wbsel", 32'(wb_sel), 32'd1);
        chk("lw_wb_strobes", strobes(), 32'b0000111);
        tick();
        chk("lw_count", retire_count, 32'd2);

        // BEQ taken then not taken
        opcode       = 7'b1100011;
        branch_taken = 1'b1;
        tick();
        tick();
        chk("beq_t_state", 32'(state), 32'd2);
        chk("beq_t_strobes", strobes(), 32'b0000011);
        chk("beq_t_pcsel", 32'(pc_sel), 32'd1);
        tick();
        chk("beq_t_next", 32'(state), 32'd0);
        chk("beq_t_count", retire_count, 32'd3);
        branch_taken = 1'b0;
        tick();
        tick();
        chk("beq_n_strobes", strobes(), 32'b0000011);
        chk("beq_n_pcsel", 32'(pc_sel), 32'd0);
        tick();
        chk("beq_n_count", retire_count, 32'd4);

        // JAL and JALR write-back selects
        opcode = 7'b1101111;
        tick();
        tick();
        tick();
        chk("jal_state", 32'(state), 32'd4);
        chk("jal_wbsel", 32'(wb_sel), 32'd2);
        chk("jal_pcsel", 32'(pc_sel), 32'd1);
        tick();
        opcode = 7'b1100111;
        tick();
        tick();
        tick();
        chk("jalr_wbsel", 32'(wb_sel), 32'd2);
        chk("jalr_pcsel", 32'(pc_sel), 32'd2);
        tick();
        chk("jalr_count", retire_count, 32'd6);

        // SW zero-wait; dmem_ready high early is ignored
        opcode     = 7'b0100011;
        dmem_ready = 1'b1;
        tick();
        chk("sw_dec_state", 32'(state), 32'd1);
        tick();
        chk("sw_exec_state", 32'(state), 32'd2);
        tick();
        chk("sw_mem_state", 32'(state), 32'd3);
        chk("sw_mem_strobes", strobes(), 32'b0011011);
        chk("sw_mem_pcsel", 32'(pc_sel), 32'd0);
        tick();
        dmem_ready = 1'b0;
        chk("sw_count", retire_count, 32'd7);

        // Instruction-memory stall
        imem_ready = 1'b0;
        #1;
        chk("istall_strobes", strobes(), 32'b1000000);
        for (int i = 0; i < 3; i++) tick();
        chk("istall_state", 32'(state), 32'd0);
        chk("istall_buserr", 32'(bus_err), 32'd0);
        imem_ready = 1'b1;

        // Illegal opcode 0x7F traps and holds
        opcode = 7'h7F;
        tick();
        chk("ill_dec_state", 32'(state), 32'd1);
        tick();
        for (int i = 0; i < 20; i++) begin
            chk("ill_trap_state", 32'(state), 32'd5);
            chk("ill_flag", 32'(illegal), 32'd1);
            chk("ill_strobes", strobes(), 32'h0);
            tick();
        end
        chk("ill_count_held", retire_count, 32'd7);
        reset = 1'b1;
        #1;
        chk("ill_rst_illegal", 32'(illegal), 32'd0);
        tick();
        chk("ill_rst_state", 32'(state), 32'd0);
        reset = 1'b0;
        #1;
        chk("ill_post_illegal", 32'(illegal), 32'd0);
        chk("ill_post_count", retire_count, 32'd0);

        // Reset in MEM during SW
        opcode = 7'b0100011;
        tick();
        tick();
        tick();
        chk("swr_mem_req", 32'(dmem_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("swr_rst_strobes", strobes(), 32'h0);
        tick();
        reset = 1'b0;
        #1;
        chk("swr_state", 32'(state), 32'd0);
        chk("swr_dmem_req", 32'(dmem_req), 32'd0);
        chk("swr_count", retire_count, 32'd0);

        // LW with dmem_ready stuck low
        opcode = 7'b0000011;
        tick();
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("to_wait_state", 32'(state), 32'd3);
            tick();
        end
`ifdef MEM_TIMEOUT_EN
        chk("to_trap_state", 32'(state), 32'd5);
        chk("to_buserr", 32'(bus_err), 32'd1);
        chk("to_illegal", 32'(illegal), 32'd0);
        chk("to_strobes", strobes(), 32'h0);
`else
        for (int i = 0; i < 6; i++) tick();
        chk("nto_state", 32'(state), 32'd3);
        chk("nto_buserr", 32'(bus_err), 32'd0);
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("to_rst_buserr", 32'(bus_err), 32'd0);

        // Ready arrives on the 4th wait cycle: normal completion
        tick();
        tick();
        tick();
        for (int i = 0; i < 3; i++) tick();
        dmem_ready = 1'b1;
        #1;
        chk("rdy_exp_state", 32'(state), 32'd3);
        tick();
        dmem_ready = 1'b0;
        chk("rdy_exp_wb", 32'(state), 32'd4);
        chk("rdy_exp_wbsel", 32'(wb_sel), 32'd1);
        chk("rdy_exp_buserr", 32'(bus_err), 32'd0);
        tick();
        chk("rdy_exp_count", retire_count, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
